// File: rtl/fmul_sched_pkg.sv
// Shared constants and state encoding for the FP multiplier scheduler.
package fmul_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ID_W    = 2;
  localparam int DEF_LAT     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fmul_scheduler_if.sv
// Requester/response bundle between ALU issue logic and the multiplier scheduler.
interface fmul_scheduler_if
  import fmul_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_a;
  logic [NUM_REQ-1:0][31:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [31:0]              rsp_data;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/floatingmultiplication.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even.
// Subnormal inputs and results are flushed to signed zero.
module floatingmultiplication (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Fmul_en,
  output logic [31:0] result
);
  logic        sign;
  logic [7:0]  ea, eb;
  logic [47:0] prod;
  logic [23:0] mant;
  logic        rnd_bit, sticky;
  logic [24:0] mr;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  int          e;

  // Normalise the 48-bit significand product, round, then pick special cases.
  always_comb begin
    sign    = A[31] ^ B[31];
    ea      = A[30:23];
    eb      = B[30:23];
    a_nan   = (ea == 8'hFF) && (A[22:0] != '0);
    b_nan   = (eb == 8'hFF) && (B[22:0] != '0);
    a_inf   = (ea == 8'hFF) && (A[22:0] == '0);
    b_inf   = (eb == 8'hFF) && (B[22:0] == '0);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    prod    = 48'({1'b1, A[22:0]}) * 48'({1'b1, B[22:0]});
    if (prod[47]) begin
      mant    = prod[47:24];
      rnd_bit = prod[23];
      sticky  = |prod[22:0];
      e       = int'(ea) + int'(eb) - 126;
    end else begin
      mant    = prod[46:23];
      rnd_bit = prod[22];
      sticky  = |prod[21:0];
      e       = int'(ea) + int'(eb) - 127;
    end
    mr = {1'b0, mant} + 25'(rnd_bit & (sticky | mant[0]));
    if (mr[24]) e = e + 1;

    result = '0;
    if (!Fmul_en)                                        result = '0;
    else if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
                                                         result = 32'h7FC0_0000;
    else if (a_inf || b_inf)                             result = {sign, 8'hFF, 23'b0};
    else if (a_zero || b_zero)                           result = {sign, 31'b0};
    else if (e >= 255)                                   result = {sign, 8'hFF, 23'b0};
    else if (e <= 0)                                     result = {sign, 31'b0};
    else result = {sign, e[7:0], mr[24] ? mr[23:1] : mr[22:0]};
  end
endmodule

// File: rtl/fmul_rr_grant.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping.
module fmul_rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);
  // Scan from rr_ptr upward modulo NUM_REQ; the first hit wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/fmul_scheduler.sv
// Time-shares one FP multiplier among NUM_REQ requesters, one op in flight.
module fmul_scheduler
  import fmul_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W,
  parameter int LAT     = DEF_LAT
) (
  input  logic              clk,
  input  logic              rst,
  fmul_scheduler_if.slave   bus
);
  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rsp_id_q, grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               any_valid;
  logic [31:0]        op_a_q, op_b_q, rsp_data_q, mul_res;
  logic [3:0]         cnt_q;
  logic               load, capture, accept;

  fmul_rr_grant #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_grant (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Multiplier sees only registered operands, so no req_* -> rsp_data path.
  floatingmultiplication u_mul (
    .A       (op_a_q),
    .B       (op_b_q),
    .Fmul_en (1'b1),
    .result  (mul_res)
  );

  // Next state and handshake strobes; ready is held low while reset is asserted.
  always_comb begin
    state_d       = state_q;
    load          = 1'b0;
    capture       = 1'b0;
    accept        = 1'b0;
    bus.req_ready = '0;
    case (state_q)
      IDLE: if (any_valid && !rst) begin
        bus.req_ready = grant_oh;
        load          = 1'b1;
        state_d       = BUSY;
      end
      BUSY: if (cnt_q == '0) begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: if (bus.rsp_ready) begin
        accept  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand latch, settle counter, result capture and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
    end else begin
      if (load) begin
        op_a_q   <= bus.req_a[grant_idx];
        op_b_q   <= bus.req_b[grant_idx];
        rsp_id_q <= grant_idx;
        cnt_q    <= 4'(LAT - 1);
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) rsp_data_q <= mul_res;
      // Next search starts just past whoever was served last.
      if (accept)
        rr_ptr_q <= (int'(rsp_id_q) == NUM_REQ - 1) ? '0 : rsp_id_q + ID_W'(1);
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: doc/fmul_scheduler.md
Name: fmul_scheduler

Overview:
- Shares one single-precision FP multiplier (module floatingmultiplication, Fmul_en tied high) between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. The block grants one request at a time in round-robin order, registers the operands, waits a fixed settle latency, then returns the product tagged with the requester index.
- Sits between the ALU issue logic and the FP multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must equal clog2(NUM_REQ).
- LAT, 2, cycles spent in BUSY before the product is captured (1..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  32*NUM_REQ  operand A of requester i in bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B of requester i, same packing as req_a.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts the product.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  32  IEEE-754 product, as produced by the multiplier.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, state=IDLE, rr_ptr=0, operand regs=0, latency counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req_valid is high, grant the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant] is high combinationally in this same cycle; the handshake completes in this cycle.
  - On the clock edge: latch req_a/req_b of the grantee into operand regs, latch the grant index into rsp_id, load counter=LAT-1, go to BUSY.
  - If no request is valid, stay in IDLE with req_ready=0.
- req_ready is zero in BUSY and DONE. Requesters must hold valid and operands stable until ready.
- BUSY:
  - Multiplier inputs come only from the operand regs; no combinational path from req_* to rsp_data.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture the multiplier result into rsp_data, go to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_id stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid drops on the next edge, rr_ptr becomes (rsp_id+1) mod NUM_REQ, state goes to IDLE.
- Latency: handshake in cycle T gives rsp_valid first high in cycle T+LAT+1.
  - Minimum issue interval with rsp_ready held high is LAT+2 cycles.
  - No pipelining; at most one operation is in flight.
- Fairness: with all requesters continuously valid, the grant order is 0,1,2,3,0,... No requester waits more than NUM_REQ-1 other grants.
- Back-pressure: rsp_ready low holds DONE indefinitely. No new grant occurs and the outputs are unchanged.
- Simultaneous events:
  - A request rising in the same cycle as the DONE→IDLE transition is seen in IDLE on the next cycle.
  - A requester dropping req_valid while another requester is granted is legal and has no effect.
- Deasserting req_valid before ready is tolerated; the request is simply not granted.
- Reset mid-operation (BUSY or DONE): the in-flight result is discarded. All outputs and rr_ptr return to reset values asynchronously.
- Arithmetic: the product is exactly the multiplier's output. The scheduler does no rounding, exception or special-value handling.

Decomposition:
- Shared package fmul_sched_pkg:
  - state encoding constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - default NUM_REQ / LAT constants.
- Sub-module fmul_rr_grant: combinational round-robin picker.
  - Inputs: req_valid vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_valid.
- The multiplier is instantiated once inside fmul_scheduler.

Test Plan:
- Single request: req0 A=0x41A00000, B=0x41F00000 (20×30). Ready pulses 1 cycle → rsp_valid at T+3 (LAT=2), rsp_id=0, rsp_data=0x44160000.
- All four valid simultaneously with distinct operands, including req1 A=0x41C80000, B=0x42340000 (25×45). Grants in order 0,1,2,3; req1 returns 0x448CA000 with rsp_id=1.
- Back-pressure: hold rsp_ready=0 for 10 cycles in DONE with a second requester pending. rsp_data stays stable, req_ready stays 0, and the second grant occurs only after the accept.
- Round-robin wrap: after serving req3, raise req0 and req2 together → req0 granted first. Then with rr_ptr=1, req2 is granted before req0.
- Reset mid-BUSY on 64×700 (0x42800000, 0x442F0000): assert rst. Outputs are 0 immediately; on restart req0 is granted and returns 0x472F0000.
- Back-to-back with rsp_ready tied high, req2 only (50×125: 0x42480000, 0x42FA0000): issue interval is 4 cycles, every result is 0x45C35000, and busy drops only in IDLE.
